phrase_sequencer: RTL and testbench
===================================

Name: phrase_sequencer

Overview:
- Reads the song's phrase-ID table position by position and emits one phrase ID per song position.
- Presents an 8-bit table address and samples the 5-bit combinational table output one cycle later.
- Holds each phrase for a fixed number of beat ticks.
- Sits between the beat/tick generator and the per-phrase note player; drives the player's phrase select and restart strobe.

Parameters:
- SONG_LEN, 153, number of song positions; positions 0..SONG_LEN-1; must be 2..256.
- TICKS_PER_PHRASE, 16, beat ticks each position lasts; must be ≥1.
- LOOP_START, 1, first position replayed after wrap; used only with the optional feature; must be < SONG_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin playback from position 0; sampled in IDLE or DONE only.
- pause  in  1  level; while high, ticks are ignored in PLAY.
- tick  in  1  one-clk beat strobe; period ≥2 clk.
- rom_addr  out  8  table address = current song position.
- rom_data  in  5  table entry for rom_addr; combinational, valid in the same cycle.
- phrase_id  out  5  registered current phrase ID; 0 = rest.
- phrase_start  out  1  one-clk pulse when phrase_id is loaded for a new position.
- busy  out  1  high in FETCH and PLAY.
- done  out  1  high in DONE.

Behaviour:
- Reset (any state, mid-playback included), next edge:
  - state=IDLE, rom_addr=0, phrase_id=0, phrase_start=0, busy=0, done=0, tick_cnt=0.
- States: IDLE, FETCH, PLAY, DONE.
- IDLE:
  - start=1 → FETCH, rom_addr<=0, tick_cnt<=0.
- FETCH (exactly 1 cycle):
  - phrase_id<=rom_data, phrase_start<=1 (pulse, cleared next cycle), tick_cnt<=0 → PLAY.
  - tick in FETCH is ignored.
- PLAY:
  - tick=1 and pause=0 with tick_cnt < TICKS_PER_PHRASE-1 → tick_cnt++.
  - tick=1 and pause=0 with tick_cnt == TICKS_PER_PHRASE-1:
    - rom_addr < SONG_LEN-1 → rom_addr++, FETCH.
    - rom_addr == SONG_LEN-1 → DONE.
  - pause=1 → tick_cnt frozen; phrase_id held.
- DONE:
  - done=1, phrase_id<=0, rom_addr<=0.
  - start=1 → FETCH at position 0; done clears the same edge.
- start while busy: ignored.
- Latency: start sampled at edge k → rom_addr=0 during cycle k..k+1 → phrase_id valid and phrase_start high after edge k+1.
- Position advance: the final tick of a position at edge j → new phrase_id and phrase_start after edge j+2.
- Widths:
  - tick_cnt is max(1, $clog2(TICKS_PER_PHRASE)) bits.
  - rom_addr is 8 bits; SONG_LEN=256 is legal; no wrap beyond SONG_LEN-1.
- Ticks are counted only in PLAY. tick and pause together: the tick is dropped.
- phrase_id value 0 is passed through as-is (rest); the sequencer does not skip it.

Optional Feature:
- Macro: PHRASE_SEQ_LOOP_EN.
- Defined:
  - After the last tick of position SONG_LEN-1, the block goes to FETCH with rom_addr<=LOOP_START instead of DONE.
  - DONE is unreachable; done is tied 0; busy stays high until rst.
  - A one-clk output loop_wrap (1 bit) pulses on the wrap edge.
- Undefined:
  - Single pass ending in DONE as above.
  - loop_wrap port absent.

Test Plan:
- Reset mid-PLAY at position 40 → next cycle phrase_id=0, rom_addr=0, busy=0, done=0; ticks then ignored until start.
- TICKS_PER_PHRASE=2, table model per song, start then tick every 4 clk:
  - phrase_start pulses exactly 153 times.
  - phrase_id at positions 0,1,2,32,33,144,152 = 0x00,0x13,0x14,0x17,0x01,0x0C,0x16.
  - done rises after the 306th tick.
- Latency: start at edge k → phrase_start high after edge k+1.
  - Final tick at edge j → new phrase_id after edge j+2; rom_addr increments after edge j.
- pause high for 10 ticks in position 5 → phrase_id unchanged, rom_addr=5 throughout; advance occurs only after TICKS_PER_PHRASE unpaused ticks.
- start pulsed during PLAY → no change. start in DONE → phrase_id=0x00 (position 0), done=0, busy=1.
- PHRASE_SEQ_LOOP_EN, SONG_LEN=153, LOOP_START=1:
  - After position 152, loop_wrap pulses and rom_addr=1, phrase_id=0x13.
  - done stays 0 across 3 full loops.

Source files
------------

// File: rtl/phrase_sequencer_if.sv
// ============================================================================
// Module   : phrase_sequencer_if
// Purpose  : Bundles the control, table and player-facing signals of
//            phrase_sequencer. PHRASE_SEQ_LOOP_EN adds the loop_wrap output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface phrase_sequencer_if;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] rom_addr;
  logic [4:0] rom_data;
  logic [4:0] phrase_id;
  logic       phrase_start;
  logic       busy;
  logic       done;
`ifdef PHRASE_SEQ_LOOP_EN
  logic       loop_wrap;
`endif

  // Sequencer side
  modport slave (
    input  start, pause, tick, rom_data,
`ifdef PHRASE_SEQ_LOOP_EN
    output loop_wrap,
`endif
    output rom_addr, phrase_id, phrase_start, busy, done
  );

  // Controller / table / player side
  modport master (
    output start, pause, tick, rom_data,
`ifdef PHRASE_SEQ_LOOP_EN
    input  loop_wrap,
`endif
    input  rom_addr, phrase_id, phrase_start, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/phrase_sequencer.sv
// ============================================================================
// Module   : phrase_sequencer
// Purpose  : Walks the song phrase table one position per TICKS_PER_PHRASE
//            beat ticks and drives the note player's phrase select/restart.
//            Define PHRASE_SEQ_LOOP_EN to loop back to LOOP_START forever.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phrase_sequencer #(
  parameter int SONG_LEN         = 153,
  parameter int TICKS_PER_PHRASE = 16,
  parameter int LOOP_START       = 1
) (
  input  logic              clk,
  input  logic              rst,
  phrase_sequencer_if.slave seq
);

  localparam int              CNT_W     = (TICKS_PER_PHRASE > 1) ? $clog2(TICKS_PER_PHRASE) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_PHRASE - 1);
  localparam logic [7:0]       LAST_POS  = 8'(SONG_LEN - 1);
`ifdef PHRASE_SEQ_LOOP_EN
  localparam logic [7:0]       LOOP_POS  = 8'(LOOP_START);
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  generate
    if (SONG_LEN < 2 || SONG_LEN > 256) begin : g_bad_song_len
      $error("phrase_sequencer: SONG_LEN must be in 2..256");
    end
    if (TICKS_PER_PHRASE < 1) begin : g_bad_ticks
      $error("phrase_sequencer: TICKS_PER_PHRASE must be at least 1");
    end
    if (LOOP_START < 0 || LOOP_START >= SONG_LEN) begin : g_bad_loop_start
      $error("phrase_sequencer: LOOP_START must be below SONG_LEN");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic [4:0]       phrase_id_q, phrase_id_d;
  logic             phrase_start_q, phrase_start_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             adv_pend_q, adv_pend_d;
`ifdef PHRASE_SEQ_LOOP_EN
  logic             loop_wrap_q, loop_wrap_d;
`endif

  logic w_tick_ok;
  logic w_last_tick;
  logic w_last_pos;
  logic w_busy;
  logic w_done;

  // A new address is held for one full cycle (adv_pend) before FETCH samples it.
  assign w_tick_ok   = (state_q == S_PLAY) && !adv_pend_q && seq.tick && !seq.pause;
  assign w_last_tick = (tick_cnt_q == LAST_TICK);
  assign w_last_pos  = (rom_addr_q == LAST_POS);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (seq.start) state_d = S_FETCH;
      S_FETCH: state_d = S_PLAY;
      S_PLAY: begin
        if (adv_pend_q) begin
          state_d = S_FETCH;
        end else if (w_tick_ok && w_last_tick && w_last_pos) begin
`ifdef PHRASE_SEQ_LOOP_EN
          state_d = S_PLAY;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE:  if (seq.start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (state_q)
      S_FETCH, S_PLAY: w_busy = 1'b1;
      S_DONE: begin
`ifdef PHRASE_SEQ_LOOP_EN
        w_done = 1'b0;
`else
        w_done = 1'b1;
`endif
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    rom_addr_d     = rom_addr_q;
    phrase_id_d    = phrase_id_q;
    phrase_start_d = 1'b0;
    tick_cnt_d     = tick_cnt_q;
    adv_pend_d     = 1'b0;
`ifdef PHRASE_SEQ_LOOP_EN
    loop_wrap_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (seq.start) begin
          rom_addr_d = 8'd0;
          tick_cnt_d = '0;
        end
      end
      S_FETCH: begin
        phrase_id_d    = seq.rom_data;
        phrase_start_d = 1'b1;
        tick_cnt_d     = '0;
      end
      S_PLAY: begin
        if (w_tick_ok) begin
          if (!w_last_tick) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
          end else if (!w_last_pos) begin
            rom_addr_d = rom_addr_q + 8'd1;
            tick_cnt_d = '0;
            adv_pend_d = 1'b1;
          end else begin
`ifdef PHRASE_SEQ_LOOP_EN
            rom_addr_d  = LOOP_POS;
            tick_cnt_d  = '0;
            adv_pend_d  = 1'b1;
            loop_wrap_d = 1'b1;
`else
            rom_addr_d  = 8'd0;
            phrase_id_d = 5'd0;
            tick_cnt_d  = '0;
`endif
          end
        end
      end
      S_DONE: begin
        rom_addr_d  = 8'd0;
        phrase_id_d = 5'd0;
        if (seq.start) tick_cnt_d = '0;
      end
      default: begin
        rom_addr_d  = 8'd0;
        phrase_id_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q     <= 8'd0;
      phrase_id_q    <= 5'd0;
      phrase_start_q <= 1'b0;
      tick_cnt_q     <= '0;
      adv_pend_q     <= 1'b0;
`ifdef PHRASE_SEQ_LOOP_EN
      loop_wrap_q    <= 1'b0;
`endif
    end else begin
      rom_addr_q     <= rom_addr_d;
      phrase_id_q    <= phrase_id_d;
      phrase_start_q <= phrase_start_d;
      tick_cnt_q     <= tick_cnt_d;
      adv_pend_q     <= adv_pend_d;
`ifdef PHRASE_SEQ_LOOP_EN
      loop_wrap_q    <= loop_wrap_d;
`endif
    end
  end

  assign seq.rom_addr     = rom_addr_q;
  assign seq.phrase_id    = phrase_id_q;
  assign seq.phrase_start = phrase_start_q;
  assign seq.busy         = w_busy;
  assign seq.done         = w_done;
`ifdef PHRASE_SEQ_LOOP_EN
  assign seq.loop_wrap    = loop_wrap_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phrase_sequencer.sv
// ============================================================================
// Module   : tb_phrase_sequencer
// Purpose  : Directed self-checking bench for phrase_sequencer with
//            TICKS_PER_PHRASE=2 and a 153-entry song table model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phrase_sequencer;
  localparam int TPP  = 2;
  localparam int SONG = 153;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phrase_sequencer_if sif();
  logic [4:0] rom_tbl [0:255];
  assign sif.rom_data = rom_tbl[sif.rom_addr];

  phrase_sequencer #(
    .SONG_LEN        (SONG),
    .TICKS_PER_PHRASE(TPP),
    .LOOP_START      (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seq(sif)
  );

  int n_total    = 0;
  int n_pass     = 0;
  int n_fail     = 0;
  int ps_cnt     = 0;
  int ticks_done = 0;

  always @(posedge clk) if (sif.phrase_start === 1'b1) ps_cnt <= ps_cnt + 1;

`ifdef PHRASE_SEQ_LOOP_EN
  int lw_cnt = 0;
  always @(posedge clk) if (sif.loop_wrap === 1'b1) lw_cnt <= lw_cnt + 1;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One beat: tick strobe for one clk, then three idle clks.
  task automatic do_tick();
    sif.tick = 1'b1;
    if (!sif.pause) ticks_done++;
    cyc();
    sif.tick = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic run_to(input int pos);
    int guard = 0;
    while (sif.rom_addr !== 8'(pos) && guard < 800) begin
      do_tick();
      guard++;
    end
    check($sformatf("reach_pos%0d", pos), 32'(sif.rom_addr), 32'(pos));
  endtask

  initial begin
    int ps_base;
    int guard;
    for (int i = 0; i < 256; i++) rom_tbl[i] = 5'((i * 11 + 7) % 32);
    rom_tbl[0]   = 5'h00;
    rom_tbl[1]   = 5'h13;
    rom_tbl[2]   = 5'h14;
    rom_tbl[32]  = 5'h17;
    rom_tbl[33]  = 5'h01;
    rom_tbl[144] = 5'h0C;
    rom_tbl[152] = 5'h16;

    sif.start = 1'b0;
    sif.pause = 1'b0;
    sif.tick  = 1'b0;
    rst = 1'b1;
    cyc(); cyc(); cyc();
    check("rst_phrase_id", 32'(sif.phrase_id), 32'h0);
    check("rst_rom_addr", 32'(sif.rom_addr), 32'h0);
    check("rst_busy", 32'(sif.busy), 32'h0);
    check("rst_done", 32'(sif.done), 32'h0);
    check("rst_phrase_start", 32'(sif.phrase_start), 32'h0);
    rst = 1'b0;
    cyc();
    ps_base = ps_cnt;

    // Start latency: phrase_start after edge k+1
    sif.start = 1'b1;
    cyc();
    sif.start = 1'b0;
    check("start_busy", 32'(sif.busy), 32'h1);
    check("start_addr", 32'(sif.rom_addr), 32'h0);
    check("start_ps_early", 32'(sif.phrase_start), 32'h0);
    cyc();
    check("start_ps", 32'(sif.phrase_start), 32'h1);
    check("start_id", 32'(sif.phrase_id), 32'h00);
    cyc();
    check("start_ps_clear", 32'(sif.phrase_start), 32'h0);

    // Position advance latency
    do_tick();
    check("pos0_hold", 32'(sif.rom_addr), 32'h0);
    sif.tick = 1'b1;
    ticks_done++;
    cyc();
    sif.tick = 1'b0;
    check("adv_addr_j", 32'(sif.rom_addr), 32'h1);
    check("adv_id_j", 32'(sif.phrase_id), 32'h00);
    cyc();
    check("adv_id_j1", 32'(sif.phrase_id), 32'h00);
    check("adv_ps_j1", 32'(sif.phrase_start), 32'h0);
    cyc();
    check("adv_id_j2", 32'(sif.phrase_id), 32'h13);
    check("adv_ps_j2", 32'(sif.phrase_start), 32'h1);
    cyc();

    run_to(2);
    check("id_pos2", 32'(sif.phrase_id), 32'h14);
    run_to(5);
    check("id_pos5", 32'(sif.phrase_id), 32'h1E);

    // Paused ticks are dropped
    sif.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      check("pause_addr", 32'(sif.rom_addr), 32'h5);
      check("pause_id", 32'(sif.phrase_id), 32'h1E);
    end
    sif.pause = 1'b0;
    do_tick();
    check("unpause_tick1", 32'(sif.rom_addr), 32'h5);
    do_tick();
    check("unpause_tick2", 32'(sif.rom_addr), 32'h6);
    check("id_pos6", 32'(sif.phrase_id), 32'h09);

    // start while busy is ignored
    sif.start = 1'b1;
    cyc();
    sif.start = 1'b0;
    check("busy_start_addr", 32'(sif.rom_addr), 32'h6);
    check("busy_start_ps", 32'(sif.phrase_start), 32'h0);
    check("busy_start_busy", 32'(sif.busy), 32'h1);
    cyc(); cyc(); cyc();
    check("busy_start_ps2", 32'(sif.phrase_start), 32'h0);
    do_tick();
    check("busy_start_cnt", 32'(sif.rom_addr), 32'h6);
    do_tick();
    check("busy_start_adv", 32'(sif.rom_addr), 32'h7);

    run_to(32);
    check("id_pos32", 32'(sif.phrase_id), 32'h17);
    run_to(33);
    check("id_pos33", 32'(sif.phrase_id), 32'h01);
    run_to(144);
    check("id_pos144", 32'(sif.phrase_id), 32'h0C);
    run_to(152);
    check("id_pos152", 32'(sif.phrase_id), 32'h16);

`ifndef PHRASE_SEQ_LOOP_EN
    guard = 0;
    while (sif.done !== 1'b1 && guard < 10) begin
      do_tick();
      guard++;
    end
    check("done_high", 32'(sif.done), 32'h1);
    check("done_tick_count", 32'(ticks_done), 32'd306);
    check("phrase_start_count", 32'(ps_cnt - ps_base), 32'd153);
    check("done_id", 32'(sif.phrase_id), 32'h0);
    check("done_addr", 32'(sif.rom_addr), 32'h0);
    check("done_busy", 32'(sif.busy), 32'h0);

    // Restart from DONE
    sif.start = 1'b1;
    cyc();
    sif.start = 1'b0;
    check("restart_done", 32'(sif.done), 32'h0);
    check("restart_busy", 32'(sif.busy), 32'h1);
    cyc();
    check("restart_ps", 32'(sif.phrase_start), 32'h1);
    check("restart_id", 32'(sif.phrase_id), 32'h00);
    cyc(); cyc();
`else
    begin
      int lw_base;
      logic done_seen;
      do_tick();
      sif.tick = 1'b1;
      cyc();
      sif.tick = 1'b0;
      check("wrap_pulse", 32'(sif.loop_wrap), 32'h1);
      check("wrap_addr", 32'(sif.rom_addr), 32'h1);
      cyc();
      check("wrap_pulse_clear", 32'(sif.loop_wrap), 32'h0);
      cyc();
      check("wrap_id", 32'(sif.phrase_id), 32'h13);
      check("wrap_ps", 32'(sif.phrase_start), 32'h1);
      cyc();
      lw_base   = lw_cnt;
      done_seen = 1'b0;
      guard     = 0;
      while ((lw_cnt - lw_base) < 3 && guard < 2000) begin
        do_tick();
        if (sif.done !== 1'b0) done_seen = 1'b1;
        guard++;
      end
      check("loop_count", 32'(lw_cnt - lw_base), 32'd3);
      check("loop_done_low", 32'(done_seen), 32'h0);
      check("loop_busy", 32'(sif.busy), 32'h1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      sif.start = 1'b1;
      cyc();
      sif.start = 1'b0;
      cyc(); cyc(); cyc();
    end
`endif

    // Reset in the middle of playback
    run_to(40);
    check("id_pos40", 32'(sif.phrase_id), 32'h1F);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_id", 32'(sif.phrase_id), 32'h0);
    check("midrst_addr", 32'(sif.rom_addr), 32'h0);
    check("midrst_busy", 32'(sif.busy), 32'h0);
    check("midrst_done", 32'(sif.done), 32'h0);
    do_tick(); do_tick(); do_tick();
    check("idle_tick_addr", 32'(sif.rom_addr), 32'h0);
    check("idle_tick_busy", 32'(sif.busy), 32'h0);
    check("idle_tick_ps", 32'(sif.phrase_start), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
